// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of the shared ALU: single-pass ops and 32x32 shift-add multiply.
// Optional build macro ALU_SEQ_MUL_EARLY_EXIT_EN ends a multiply once the remaining multiplier bits are zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; ALU driven with 0 + 0
// EXEC     | one ALU pass with the latched function code
// MUL_STEP | one shift-add iteration; the add runs on the ALU
// DONE     | result valid, done pulse; a start seen here is dropped
module alu_seq_ctrl #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] FUNC_ADD   = 4'b0000,
    parameter int         MUL_STEPS  = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_mul,
    input  logic [3:0]            func_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] alu_dataa,
    output logic [DATA_WIDTH-1:0] alu_datab,
    output logic [3:0]            alu_func,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
`ifndef ALU_SEQ_MUL_EARLY_EXIT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_MUL_STEP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [3:0]            r_func;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  w_mul_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        alu_dataa  = '0;
        alu_datab  = '0;
        alu_func   = FUNC_ADD;
        w_mul_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = op_mul ? S_MUL_STEP : S_EXEC;
            end
            // Single-op operands reuse the multiplicand/multiplier registers.
            S_EXEC: begin
                alu_dataa = r_mcand;
                alu_datab = r_mplier;
                alu_func  = r_func;
                w_next    = S_DONE;
            end
            S_MUL_STEP: begin
                alu_dataa = r_acc;
                alu_datab = r_mplier[0] ? r_mcand : '0;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
                w_mul_last = ((r_mplier >> 1) == '0);
`else
                w_mul_last = (r_count == CNT_LAST);
`endif
                if (w_mul_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_func   <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= a_in;
                        r_mplier <= b_in;
                        r_func   <= func_in;
                        r_count  <= '0;
                    end
                end
                S_EXEC: r_result <= alu_result;
                S_MUL_STEP: begin
                    r_acc    <= alu_result;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_mul_last) r_result <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU stub, vector table, corner sequences, random commands.
// Expected multiply latency follows ALU_SEQ_MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_alu_seq_ctrl;

    localparam int STEPS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_mul;
    logic [3:0]  func_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_dataa;
    logic [31:0] alu_datab;
    logic [3:0]  alu_func;
    logic [31:0] alu_result;

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_mul     (op_mul),
        .func_in    (func_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_dataa  (alu_dataa),
        .alu_datab  (alu_datab),
        .alu_func   (alu_func),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'h0:    return a + b;
            4'h1:    return a & b;
            4'h2:    return a - b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[4:0];
            4'h6:    return a >> b[4:0];
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_func, alu_dataa, alu_datab);

    function automatic logic [31:0] exp_result(input logic m, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        if (m) return 32'(a * b);
        return alu_model(f, a, b);
    endfunction

    function automatic int exp_lat(input logic m, input logic [31:0] b);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        int hi;
`endif
        if (!m) return 2;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        hi = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hi = i;
        return hi + 2;
`else
        return STEPS + 1;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    // inj > 0 pulses an unrelated SUB start during that cycle of the command.
    task automatic run_cmd(input logic m, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int inj, output logic [31:0] res, output int lat, output int nd, output int nbusy);
        start = 1'b1; op_mul = m; func_in = f; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
        res = '0; lat = -1; nd = 0; nbusy = 0;
        if (!m) begin
            check("exec_dataa", alu_dataa, a);
            check("exec_datab", alu_datab, b);
            check("exec_func", {28'b0, alu_func}, {28'b0, f});
        end else begin
            check("mul1_dataa", alu_dataa, 32'd0);
            check("mul1_datab", alu_datab, b[0] ? a : 32'd0);
            check("mul1_func", {28'b0, alu_func}, 32'd0);
        end
        for (int c = 1; c <= 60; c++) begin
            if (busy) nbusy++;
            if (done) begin
                nd++;
                lat = c;
                res = result;
            end
            start = (c == inj);
            if (c == inj) begin
                op_mul = 1'b0; func_in = 4'h2; a_in = 32'd5; b_in = 32'd3;
            end
            if (!busy) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic quiet(input string nm);
        int nb;
        nb = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) nb++;
        end
        check(nm, 32'(nb), 32'd0);
    endtask

    typedef struct {
        logic        m;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] res;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rf;
        logic        rm;
        int          lat;
        int          nd;
        int          nbusy;
        int          inj;
        int          rc;

        vecs[0] = '{1'b0, 4'h2, 32'd100,        32'd58,         32'd42};
        vecs[1] = '{1'b1, 4'h0, 32'd7,          32'd6,          32'd42};
        vecs[2] = '{1'b1, 4'h0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
        vecs[3] = '{1'b1, 4'h0, 32'h00010000,   32'h00010000,   32'h00000000};
        vecs[4] = '{1'b0, 4'h0, 32'hFFFFFFFF,   32'h00000001,   32'h00000000};
        vecs[5] = '{1'b0, 4'h1, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000};
        vecs[6] = '{1'b0, 4'hF, 32'h12345678,   32'h0F0F0F0F,   32'hE2C4A688};
        vecs[7] = '{1'b1, 4'h7, 32'd12345,      32'd0,          32'd0};
        vecs[8] = '{1'b1, 4'h0, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE};
        vecs[9] = '{1'b1, 4'h0, 32'd1,          32'h80000000,   32'h80000000};

        rst = 1'b1; start = 1'b0; op_mul = 1'b0; func_in = 4'h0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_func", {28'b0, alu_func}, 32'd0);
        check("rst_dataa", alu_dataa, 32'd0);
        check("rst_datab", alu_datab, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].m, vecs[i].f, vecs[i].a, vecs[i].b, 0, res, lat, nd, nbusy);
            check("vec_result", res, vecs[i].exp);
            check("vec_latency", 32'(lat), 32'(exp_lat(vecs[i].m, vecs[i].b)));
            check("vec_ndone", 32'(nd), 32'd1);
            check("vec_busy_cycles", 32'(nbusy), 32'(exp_lat(vecs[i].m, vecs[i].b)));
            check("vec_result_held", result, vecs[i].exp);
            check("idle_dataa", alu_dataa, 32'd0);
        end

        // Second start while a multiply is running must be dropped.
        inj = (exp_lat(1'b1, 32'd4) > 10) ? 10 : exp_lat(1'b1, 32'd4) - 1;
        run_cmd(1'b1, 4'h0, 32'd3, 32'd4, inj, res, lat, nd, nbusy);
        check("busy_start_result", res, 32'd12);
        check("busy_start_ndone", 32'(nd), 32'd1);
        check("busy_start_latency", 32'(lat), 32'(exp_lat(1'b1, 32'd4)));
        quiet("busy_start_not_queued");
        check("busy_start_held", result, 32'd12);

        // Start arriving in the DONE cycle must be dropped as well.
        run_cmd(1'b0, 4'h2, 32'd20, 32'd5, 2, res, lat, nd, nbusy);
        check("done_start_result", res, 32'd15);
        check("done_start_ndone", 32'(nd), 32'd1);
        quiet("done_start_not_queued");

        // Reset in the middle of a multiply aborts it.
        rc = (exp_lat(1'b1, 32'd9) > 15) ? 15 : exp_lat(1'b1, 32'd9) - 2;
        start = 1'b1; op_mul = 1'b1; func_in = 4'h0; a_in = 32'd9; b_in = 32'd9;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int c = 1; c <= rc; c++) begin
            if (done) nd++;
            if (c == rc) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_ndone", 32'(nd), 32'd0);
        quiet("midrst_quiet");
        run_cmd(1'b1, 4'h0, 32'd9, 32'd9, 0, res, lat, nd, nbusy);
        check("midrst_reissue", res, 32'd81);
        check("midrst_reissue_lat", 32'(lat), 32'(exp_lat(1'b1, 32'd9)));

        for (int i = 0; i < 30; i++) begin
            rm = 1'($urandom_range(0, 1));
            rf = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_cmd(rm, rf, ra, rb, 0, res, lat, nd, nbusy);
            check("rand_result", res, exp_result(rm, rf, ra, rb));
            check("rand_latency", 32'(lat), 32'(exp_lat(rm, rb)));
            check("rand_ndone", 32'(nd), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer in front of the shared 32-bit ALU: accepts one command at a time and drives the ALU's dataa, datab and Function inputs.
- Two command types:
  - Single op: one ALU pass with a caller-supplied Function code.
  - Multiply: 32x32 shift-add multiply returning the low 32 bits. The add step runs on the ALU using Function ADD.
- Sits between the EX-stage decode and the ALU; lets multi-cycle MUL reuse the existing adder.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match ALU width.
- FUNC_ADD, 4'b0000, ALU Function code for ADD.
- MUL_STEPS, 32, shift-add iterations per multiply (= DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op_mul  input  1  1 = multiply, 0 = single ALU op.
- func_in  input  4  ALU Function code for a single op; ignored for multiply.
- a_in  input  32  operand A (multiplicand for MUL).
- b_in  input  32  operand B (multiplier for MUL).
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  32  registered result; held until the next done.
- alu_dataa  output  32  to ALU dataa.
- alu_datab  output  32  to ALU datab.
- alu_func  output  4  to ALU Function.
- alu_result  input  32  from ALU result (combinational ALU).

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, internal acc/mcand/mplier/count=0.
- Reset mid-operation aborts the command: no done pulse, result forced to 0.
- States: IDLE, EXEC, MUL_STEP, DONE.
- IDLE:
  - alu_dataa=0, alu_datab=0, alu_func=FUNC_ADD.
  - On start=1: latch a_in, b_in, func_in. Go to EXEC if op_mul=0, else MUL_STEP with acc=0, mcand=a_in, mplier=b_in, count=0.
- start while busy=1 is ignored; it is not queued.
- EXEC (1 cycle):
  - alu_dataa=A, alu_datab=B, alu_func=latched func.
  - result<=alu_result; go to DONE.
- MUL_STEP (1 cycle per iteration):
  - alu_dataa=acc, alu_datab=(mplier[0] ? mcand : 0), alu_func=FUNC_ADD.
  - acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1 (logical); count<=count+1.
  - When count==MUL_STEPS-1: result<=alu_result and go to DONE.
- DONE (1 cycle): done=1, busy=1; next state IDLE. A start arriving in DONE is ignored.
- Latency, counted from the start edge:
  - Single op: done asserted in cycle 2.
  - Multiply: done asserted in cycle MUL_STEPS+1 (33).
  - Back-to-back issue interval: single op 3 cycles; multiply 34 cycles.
- Arithmetic: product is modulo 2^32, valid for both signed and unsigned operands; no overflow flag. Undefined func codes pass straight to the ALU; result is whatever the ALU returns.
- busy and done are registered state decodes; the alu_* outputs are combinational from state and registers.

Optional Feature:
- Macro: ALU_SEQ_MUL_EARLY_EXIT_EN.
- Defined: in MUL_STEP, if the next mplier value (mplier>>1) is 0, capture result<=alu_result and go to DONE immediately.
  - Multiply latency becomes (index of highest set bit of b_in)+2 cycles.
  - Minimum one MUL_STEP, including b_in=0.
- Undefined: always exactly MUL_STEPS iterations.
- The result value is identical in both builds.

Test Plan:
- Reset then idle: rst high 2 cycles -> busy=0, done=0, result=0, alu_func=4'b0000, alu_dataa=alu_datab=0.
- Single SUB: start, op_mul=0, func_in=4'b0010, a=100, b=58 -> done pulse in cycle 2, result=42, busy high cycles 1-2.
- MUL 7*6 -> result=42. done at cycle 33 without the macro; with the macro, done at cycle 4 after 3 MUL_STEP cycles.
- MUL wrap: 0xFFFFFFFF*0xFFFFFFFF -> result=0x00000001; 0x00010000*0x00010000 -> result=0.
- Start ignored while busy: second start (SUB 5-3) pulsed in cycle 10 of a MUL 3*4 -> exactly one done pulse, result=12, state returns to IDLE.
- Reset mid-MUL: rst in cycle 15 of MUL 9*9 -> IDLE next cycle, result=0, no done pulse. A new MUL 9*9 issued afterwards gives 81.
